// File: rtl/timer_counter.sv
// Timebase stage: prescaled tick, 8-bit period counter (free-run / one-shot), sticky match and overflow flags.
// Optional down counting with a count_dir input is enabled by defining TIMER_CNT_DOWN_EN.
module timer_counter #(
  parameter int NUM_COMP = 3,
  parameter int PRESC_W  = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic                     one_shot,
  input  logic                     sw_clear,
`ifdef TIMER_CNT_DOWN_EN
  input  logic                     count_dir,
`endif
  input  logic [PRESC_W-1:0]       presc_div,
  input  logic [7:0]               period,
  input  logic [NUM_COMP-1:0][7:0] match_value,
  input  logic [NUM_COMP-1:0]      flag_clr,
  input  logic                     ovf_clr,
  output logic [7:0]               counter_value,
  output logic [NUM_COMP-1:0]      flag,
  output logic                     ovf_flag,
  output logic                     running
);

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_t;

  state_t              r_state, w_state_nxt;
  logic [PRESC_W-1:0]  r_presc, w_presc_nxt;
  logic [7:0]          r_count, w_count_nxt;
  logic [NUM_COMP-1:0] r_flag, w_flag_set;
  logic                r_ovf, w_ovf_set;
  logic                w_tick, w_load, w_dn;

  always_comb begin
    // NOTE: every signal written here gets a default first so no path can infer a latch.
    w_state_nxt = r_state;
    w_presc_nxt = r_presc;
    w_count_nxt = r_count;
    w_load      = 1'b0;
    w_ovf_set   = 1'b0;
    w_flag_set  = '0;
    w_dn        = 1'b0;
`ifdef TIMER_CNT_DOWN_EN
    w_dn        = count_dir;
`endif
    w_tick = (r_state == ST_RUN) && en && !sw_clear && (r_presc >= presc_div);

    if (sw_clear) begin
      w_state_nxt = en ? ST_RUN : ST_IDLE;
      w_presc_nxt = '0;
      w_count_nxt = w_dn ? period : 8'd0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          w_presc_nxt = '0;
          if (en) w_state_nxt = ST_RUN;
        end
        ST_RUN: begin
          if (!en) begin
            w_state_nxt = ST_IDLE;
            w_presc_nxt = '0;
          end else if (w_tick) begin
            w_presc_nxt = '0;
            if (w_dn) begin
              if ((r_count == 8'd0) || (r_count > period)) begin
                w_ovf_set = 1'b1;
                if (one_shot) begin
                  w_count_nxt = 8'd0;
                  w_state_nxt = ST_DONE;
                end else begin
                  w_count_nxt = period;
                  w_load      = 1'b1;
                end
              end else begin
                w_count_nxt = r_count - 8'd1;
                w_load      = 1'b1;
              end
            end else begin
              // >= rather than == so a period lowered below the count wraps at once.
              if (r_count >= period) begin
                w_ovf_set = 1'b1;
                if (one_shot) begin
                  w_state_nxt = ST_DONE;
                end else begin
                  w_count_nxt = 8'd0;
                  w_load      = 1'b1;
                end
              end else begin
                w_count_nxt = r_count + 8'd1;
                w_load      = 1'b1;
              end
            end
          end else begin
            w_presc_nxt = r_presc + PRESC_W'(1);
          end
        end
        ST_DONE: begin
          w_presc_nxt = '0;
          if (!en) w_state_nxt = ST_IDLE;
        end
        default: w_state_nxt = ST_IDLE;
      endcase
    end

    // Flags only fire on a genuine load, never on a held value.
    for (int i = 0; i < NUM_COMP; i++)
      w_flag_set[i] = w_load && (w_count_nxt == match_value[i]);
  end

  always_ff @(posedge clk or negedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (!rst) begin
      r_state <= ST_IDLE;
      r_presc <= '0;
      r_count <= 8'd0;
      r_flag  <= '0;
      r_ovf   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_presc <= w_presc_nxt;
      r_count <= w_count_nxt;
      r_flag  <= (r_flag & ~flag_clr) | w_flag_set;
      r_ovf   <= (r_ovf & ~ovf_clr) | w_ovf_set;
    end
  end

  assign counter_value = r_count;
  assign flag          = r_flag;
  assign ovf_flag      = r_ovf;
  assign running       = (r_state == ST_RUN);

endmodule

// File: tb/tb_timer_counter.sv
// Directed self-checking bench for timer_counter; down-count steps run only when TIMER_CNT_DOWN_EN is defined.
module tb_timer_counter;

  logic            clk = 1'b0;
  logic            rst, en, one_shot, sw_clear, ovf_clr;
  logic            count_dir;
  logic [7:0]      presc_div, period;
  logic [2:0][7:0] match_value;
  logic [2:0]      flag_clr;
  logic [7:0]      counter_value;
  logic [2:0]      flag;
  logic            ovf_flag, running;

  int n_tests = 0;
  int n_fail  = 0;

  timer_counter #(.NUM_COMP(3), .PRESC_W(8)) dut (
    .clk           (clk),
    .rst           (rst),
    .en            (en),
    .one_shot      (one_shot),
    .sw_clear      (sw_clear),
`ifdef TIMER_CNT_DOWN_EN
    .count_dir     (count_dir),
`endif
    .presc_div     (presc_div),
    .period        (period),
    .match_value   (match_value),
    .flag_clr      (flag_clr),
    .ovf_clr       (ovf_clr),
    .counter_value (counter_value),
    .flag          (flag),
    .ovf_flag      (ovf_flag),
    .running       (running)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0; en = 1'b0; one_shot = 1'b0; sw_clear = 1'b0; ovf_clr = 1'b0;
    count_dir = 1'b0; presc_div = 8'd0; period = 8'd4; flag_clr = 3'b000;
    match_value[0] = 8'd200; match_value[1] = 8'd200; match_value[2] = 8'd200;
    #12;
    check("rst_count", counter_value, 0);
    check("rst_flag", flag, 0);
    check("rst_ovf", ovf_flag, 0);
    check("rst_running", running, 0);

    // Free-run wrap, period 4, prescaler bypassed.
    rst = 1'b1; en = 1'b1;
    step();
    check("start_running", running, 1);
    check("start_count", counter_value, 0);
    step(); check("wrap_c1", counter_value, 1);
    step(); check("wrap_c2", counter_value, 2);
    step(); check("wrap_c3", counter_value, 3);
    step(); check("wrap_c4", counter_value, 4);
    check("wrap_ovf_before", ovf_flag, 0);
    step(); check("wrap_c0", counter_value, 0);
    check("wrap_ovf_after", ovf_flag, 1);
    step(); check("wrap_c1b", counter_value, 1);

    // Prescaler /3 with pause and resume.
    sw_clear = 1'b1; en = 1'b0; ovf_clr = 1'b1; presc_div = 8'd2; period = 8'd255;
    step();
    check("clr_count", counter_value, 0);
    check("clr_running", running, 0);
    check("clr_ovf", ovf_flag, 0);
    sw_clear = 1'b0; ovf_clr = 1'b0; en = 1'b1;
    step(); check("presc_running", running, 1);
    for (int k = 1; k <= 5; k++) begin
      step(); step();
      check("presc_hold", counter_value, k - 1);
      step();
      check("presc_tick", counter_value, k);
    end
    en = 1'b0;
    step();
    check("pause_running", running, 0);
    check("pause_count", counter_value, 5);
    step(); step();
    check("pause_held", counter_value, 5);
    en = 1'b1;
    step(); check("resume_running", running, 1);
    step(); step();
    check("resume_hold", counter_value, 5);
    step();
    check("resume_tick", counter_value, 6);

    // Match flags, wrap flag and set-beats-clear.
    sw_clear = 1'b1; en = 1'b0; presc_div = 8'd0; period = 8'd20;
    match_value[0] = 8'd10; match_value[1] = 8'd20; match_value[2] = 8'd0;
    step();
    check("mclr_flag", flag, 0);
    sw_clear = 1'b0; en = 1'b1;
    step();
    for (int k = 1; k <= 20; k++) begin
      step();
      if (k == 9)  check("match_k9", flag, 3'b000);
      if (k == 10) check("match_k10", flag, 3'b001);
      if (k == 20) check("match_k20", flag, 3'b011);
    end
    step();
    check("match_wrap_count", counter_value, 0);
    check("match_wrap_flag", flag, 3'b111);
    for (int k = 1; k <= 9; k++) step();
    flag_clr = 3'b001;
    step();
    check("setwins_count", counter_value, 10);
    check("setwins_flag", flag, 3'b111);
    step();
    check("clr_flag0", flag, 3'b110);
    flag_clr = 3'b000;

    // One-shot stop at 7 and re-arm.
    sw_clear = 1'b1; en = 1'b0; flag_clr = 3'b111; ovf_clr = 1'b1;
    match_value[0] = 8'd200; match_value[1] = 8'd200; match_value[2] = 8'd200;
    one_shot = 1'b1; period = 8'd7;
    step();
    check("os_clr_flag", flag, 0);
    check("os_clr_ovf", ovf_flag, 0);
    sw_clear = 1'b0; flag_clr = 3'b000; ovf_clr = 1'b0; en = 1'b1;
    step();
    for (int k = 1; k <= 7; k++) step();
    check("os_at7", counter_value, 7);
    check("os_at7_ovf", ovf_flag, 0);
    step();
    check("os_done_count", counter_value, 7);
    check("os_done_running", running, 0);
    check("os_done_ovf", ovf_flag, 1);
    step();
    check("os_done_held", counter_value, 7);
    sw_clear = 1'b1;
    step();
    check("rearm_count", counter_value, 0);
    check("rearm_running", running, 1);
    sw_clear = 1'b0;
    step();
    check("rearm_tick", counter_value, 1);

    // Lowered period forces a wrap; sw_clear beats a tick.
    one_shot = 1'b0; period = 8'd255; ovf_clr = 1'b1;
    step();
    check("lp_count2", counter_value, 2);
    check("lp_ovf_clr", ovf_flag, 0);
    ovf_clr = 1'b0;
    for (int k = 0; k < 48; k++) step();
    check("lp_count50", counter_value, 50);
    period = 8'd30;
    step();
    check("lp_wrap_count", counter_value, 0);
    check("lp_wrap_ovf", ovf_flag, 1);
    ovf_clr = 1'b1; match_value[0] = 8'd0; period = 8'd3;
    step(); ovf_clr = 1'b0;
    step(); step();
    check("swc_pre_count", counter_value, 3);
    sw_clear = 1'b1;
    step();
    check("swc_count", counter_value, 0);
    check("swc_ovf", ovf_flag, 0);
    check("swc_flag", flag, 0);

    // Asynchronous reset mid-count.
    sw_clear = 1'b0; match_value[0] = 8'd200; match_value[1] = 8'd5; period = 8'd255;
    for (int k = 0; k < 12; k++) step();
    check("ar_pre_count", counter_value, 12);
    check("ar_pre_flag", flag, 3'b010);
    #3 rst = 1'b0;
    #1;
    check("ar_count", counter_value, 0);
    check("ar_flag", flag, 0);
    check("ar_running", running, 0);

`ifdef TIMER_CNT_DOWN_EN
    #2 rst = 1'b1;
    count_dir = 1'b1; period = 8'd3; sw_clear = 1'b1; en = 1'b1; ovf_clr = 1'b0;
    step();
    check("dn_load", counter_value, 3);
    check("dn_running", running, 1);
    sw_clear = 1'b0;
    step(); check("dn_2", counter_value, 2);
    step(); check("dn_1", counter_value, 1);
    step(); check("dn_0", counter_value, 0);
    check("dn_ovf_before", ovf_flag, 0);
    step(); check("dn_reload", counter_value, 3);
    check("dn_ovf_after", ovf_flag, 1);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/timer_counter.md
Name: timer_counter

Overview:
Timebase stage of the timer, sitting directly upstream of the compare/output stage. It generates a prescaled tick and an 8-bit period counter with free-running and one-shot modes. It also maintains the sticky per-comparator match flags and the overflow flag. counter_value and flag feed the output stage; intr enables and PWM logic remain downstream.

Parameters:
NUM_COMP, 3, number of compare channels (flag width, match_value depth)
PRESC_W, 8, prescaler divider width

Ports:
clk  input  1  timer clock, all logic on rising edge
rst  input  1  asynchronous, active-low reset (0 = reset)
en  input  1  count enable; 0 pauses (counter held)
one_shot  input  1  1 = stop at period, 0 = wrap
sw_clear  input  1  synchronous clear of counter and prescaler
presc_div  input  PRESC_W  tick every presc_div+1 clk cycles
period  input  8  top value; count range 0..period
match_value  input  [NUM_COMP-1:0][7:0]  compare values
flag_clr  input  NUM_COMP  write-1-to-clear for flag
ovf_clr  input  1  write-1-to-clear for ovf_flag
counter_value  output  8  current count
flag  output  NUM_COMP  sticky match flags
ovf_flag  output  1  sticky wrap/one-shot-done flag
running  output  1  1 when state is RUN

Behaviour:
- Reset (rst=0, async): state IDLE, counter_value=0, prescaler=0, flag=0, ovf_flag=0, running=0.
- FSM states and transitions:
  - IDLE: en=1 -> RUN.
  - RUN: en=0 -> IDLE (pause: counter held, prescaler cleared). One-shot terminal tick -> DONE.
  - DONE: counter held at period. en=0 -> IDLE. sw_clear=1 with en=1 -> RUN (re-arm).
- Prescaler: counts only in RUN.
  - tick = RUN & (presc_cnt >= presc_div); on tick presc_cnt <= 0, otherwise presc_cnt+1.
  - presc_div=0 gives a tick every cycle.
  - Using >= means a lowered presc_div mid-count ticks on the next cycle.
- Counter, on tick:
  - counter_value >= period, one_shot=0: load 0 and set ovf_flag.
  - counter_value >= period, one_shot=1: hold, go to DONE, set ovf_flag.
  - Otherwise: counter_value+1.
  - period=0: counter stays 0; ovf_flag sets on every tick.
  - A lowered period below the current count forces a wrap on the next tick.
- Latency: en sampled high at edge N -> running=1 after edge N. With presc_div=0, counter_value increments at edge N+1.
- Flags: flag[i] sets on the edge where the counter loads a value equal to match_value[i]. Flag and counter update on the same edge.
  - No flag sets for the value held after reset or pause.
  - Wrap to 0 sets flag[i] when match_value[i]=0.
- Clear priority: on a simultaneous set and clear (flag_clr[i] / ovf_clr), set wins. Flag clear takes effect at the next edge.
- sw_clear: counter=0 and prescaler=0 at the next edge. It overrides any tick in the same cycle and does not set flags. State becomes RUN if en=1, else IDLE.
- Reset mid-operation returns everything to reset values immediately, regardless of clk.
- Arithmetic: all 8-bit unsigned. Counter never exceeds 255 and has no carry-out beyond the wrap logic.

Optional Feature:
TIMER_CNT_DOWN_EN
- Defined: adds input count_dir (1 bit, 1 = down).
  - Down counting decrements on tick.
  - At counter_value == 0 (or > period), a tick loads period (free-run) or holds 0 and enters DONE (one-shot). Either case sets ovf_flag.
  - sw_clear loads period when count_dir=1.
  - Changing count_dir mid-count reverses from the current value on the next tick.
- Undefined: count_dir port absent; up-count only, as above.

Test Plan:
- Reset release, en=1, presc_div=0, period=4, one_shot=0 -> counter 1,2,3,4,0,1 on successive edges; ovf_flag=1 after edge where 0 loads.
- presc_div=2, period=255 -> counter increments every 3 cycles; en low at count 5 -> held at 5, running=0; en high again -> 6 after 3 cycles.
- match_value={10,20,0}, period=20, presc_div=0 -> flag[0] at counter=10, flag[1] at 20, flag[2] on wrap to 0. flag_clr=3'b001 in the cycle counter loads 10 again -> flag[0] stays 1.
- one_shot=1, period=7 -> counter stops at 7, state DONE, ovf_flag=1; sw_clear with en=1 -> counter 0, running=1, counts again.
- Count at 50, period written to 30 -> next tick wraps to 0, ovf_flag=1; sw_clear same cycle as tick -> counter 0, no flag set.
- rst=0 asserted mid-count (counter=12, flags set) without clk edge -> all outputs 0 immediately; with TIMER_CNT_DOWN_EN, count_dir=1, period=3 -> 3,2,1,0,3.
